// File: rtl/snes_poll_sched.sv
// SNES pad poll sequencer: drives latch/data-clock, shifts in the serial word, publishes a registered button word.
// Optional build macro SNES_CHANGE_EN adds a buttons_changed strobe alongside buttons_valid.
module snes_poll_sched #(
  parameter int HALF_CYC    = 60,
  parameter int NUM_BITS    = 16,
  parameter int POLL_PERIOD = 166667
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                auto_en,
  input  logic                poll_req,
  input  logic                snes_data,
  output logic                snes_latch,
  output logic                snes_clk,
  output logic [NUM_BITS-1:0] buttons,
  output logic                buttons_valid,
  output logic                busy,
  output logic                buttons_changed
);

  localparam int PW = $clog2(2 * HALF_CYC);
  localparam int IW = $clog2(NUM_BITS);
  localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_CYC - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_BITS - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GAP,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                pending_q, pending_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [NUM_BITS-1:0] buttons_q, buttons_d;
  logic                valid_q, valid_d;
  logic                latch_q, sclk_q, busy_q;
  logic                timer_tick;
  logic                phase_last;
  logic                start;

  // Period timer runs free of the FSM; it only matters while auto_en is high.
  always_comb begin
    timer_tick = auto_en && (timer_q == TIMER_LAST);
    timer_d    = timer_q + TW'(1);
    if (!auto_en || timer_tick) begin
      timer_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    buttons_d  = buttons_q;
    valid_d    = 1'b0;
    start      = 1'b0;
    phase_last = (state_q == S_LATCH) ? (phase_q == LATCH_LAST) : (phase_q == HALF_LAST);

    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        idx_d   = '0;
        if (poll_req || pending_q || timer_tick) begin
          state_d = S_LATCH;
          start   = 1'b1;
        end
      end
      S_LATCH: begin
        phase_d = phase_q + PW'(1);
        if (phase_last) begin
          phase_d = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        phase_d = phase_q + PW'(1);
        if (phase_last) begin
          phase_d    = '0;
          shift_d[0] = ~snes_data;
          idx_d      = IW'(1);
          state_d    = S_LOW;
        end
      end
      S_LOW: begin
        phase_d = phase_q + PW'(1);
        if (phase_last) begin
          phase_d = '0;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        phase_d = phase_q + PW'(1);
        if (phase_last) begin
          phase_d        = '0;
          shift_d[idx_q] = ~snes_data;
          if (idx_q < IDX_LAST) begin
            idx_d   = idx_q + IW'(1);
            state_d = S_LOW;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        buttons_d = shift_q;
        valid_d   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One-deep pending flag absorbs any requests seen while a poll is running.
  always_comb begin
    pending_d = pending_q;
    if (start) begin
      pending_d = 1'b0;
    end else if ((state_q != S_IDLE) && (poll_req || timer_tick)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      pending_q <= 1'b0;
      shift_q   <= '0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      sclk_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      // Pad pins come straight from flops so they never glitch on state decode.
      latch_q   <= (state_d == S_LATCH);
      sclk_q    <= (state_d != S_LOW);
      busy_q    <= (state_d != S_IDLE);
    end
  end

`ifdef SNES_CHANGE_EN
  logic changed_q, changed_d;

  always_comb begin
    changed_d = (state_q == S_DONE) && (shift_q != buttons_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign buttons_changed = changed_q;
`else
  assign buttons_changed = 1'b0;
`endif

  assign snes_latch    = latch_q;
  assign snes_clk      = sclk_q;
  assign buttons       = buttons_q;
  assign buttons_valid = valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_snes_poll_sched.sv
// Directed bench for snes_poll_sched with HALF_CYC=2, NUM_BITS=4, POLL_PERIOD=100 (19-cycle polls).
module tb_snes_poll_sched;

  localparam int HALF_CYC    = 2;
  localparam int NUM_BITS    = 4;
  localparam int POLL_PERIOD = 100;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                auto_en;
  logic                poll_req;
  logic                snes_data;
  logic                snes_latch;
  logic                snes_clk;
  logic [NUM_BITS-1:0] buttons;
  logic                buttons_valid;
  logic                busy;
  logic                buttons_changed;

  snes_poll_sched #(
    .HALF_CYC   (HALF_CYC),
    .NUM_BITS   (NUM_BITS),
    .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .auto_en        (auto_en),
    .poll_req       (poll_req),
    .snes_data      (snes_data),
    .snes_latch     (snes_latch),
    .snes_clk       (snes_clk),
    .buttons        (buttons),
    .buttons_valid  (buttons_valid),
    .busy           (busy),
    .buttons_changed(buttons_changed)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Monitor and pad model, evaluated on the falling edge, away from the active edge.
  logic [NUM_BITS-1:0] pad_word = '0;
  int pad_idx = 0;
  int cyc = 0;
  int latch_starts[$];
  int valid_cycles[$];
  int low_lens[$];
  int latch_cyc = 0;
  int low_pulses = 0;
  int low_run = 0;
  int changed_cnt = 0;
  int changed_orphan = 0;
  logic latch_prev = 1'b0;
  logic sclk_prev = 1'b1;

  initial snes_data = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      latch_prev = 1'b0;
      sclk_prev  = 1'b1;
      low_run    = 0;
    end else begin
      if (snes_latch) begin
        latch_cyc++;
        if (!latch_prev) latch_starts.push_back(cyc);
        pad_idx = 0;
      end else if (snes_clk && !sclk_prev) begin
        if (pad_idx < NUM_BITS - 1) pad_idx++;
      end
      if (!snes_clk) begin
        if (sclk_prev) low_pulses++;
        low_run++;
      end else if (!sclk_prev) begin
        low_lens.push_back(low_run);
        low_run = 0;
      end
      if (buttons_valid) valid_cycles.push_back(cyc);
      if (buttons_changed) begin
        changed_cnt++;
        if (!buttons_valid) changed_orphan++;
      end
      latch_prev = snes_latch;
      sclk_prev  = snes_clk;
    end
    snes_data = ~pad_word[pad_idx];
  end

  int b_ls, b_vc, b_ll, b_lc, b_lp, b_ch;

  task automatic snap();
    b_ls = latch_starts.size();
    b_vc = valid_cycles.size();
    b_ll = low_lens.size();
    b_lc = latch_cyc;
    b_lp = low_pulses;
    b_ch = changed_cnt;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    poll_req = 1'b1;
    cycles(1);
    poll_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n  = 1'b0;
    auto_en  = 1'b0;
    poll_req = 1'b0;
    cycles(3);
    reset_n = 1'b1;

    check("rst_latch", snes_latch, 0);
    check("rst_sclk", snes_clk, 1);
    check("rst_busy", busy, 0);
    check("rst_buttons", buttons, 0);
    check("rst_valid", buttons_valid, 0);
    check("rst_changed", buttons_changed, 0);

    // Idle with nothing asking for a poll
    snap();
    cycles(200);
    check("idle_latches", latch_starts.size() - b_ls, 0);
    check("idle_valids", valid_cycles.size() - b_vc, 0);
    check("idle_lows", low_pulses - b_lp, 0);
    check("idle_sclk", snes_clk, 1);
    check("idle_busy", busy, 0);

    // Single on-demand poll, bits 0..3 = 0,1,0,1
    pad_word = 4'b1010;
    snap();
    pulse_req();
    cycles(4);
    check("single_busy_mid", busy, 1);
    cycles(30);
    check("single_busy_end", busy, 0);
    check("single_latches", latch_starts.size() - b_ls, 1);
    check("single_latch_len", latch_cyc - b_lc, 4);
    check("single_low_pulses", low_pulses - b_lp, 3);
    for (int i = 0; i < 3; i++) begin
      if (low_lens.size() > b_ll + i) check($sformatf("single_low_len%0d", i), low_lens[b_ll+i], 2);
      else check($sformatf("single_low_len%0d_missing", i), 0, 1);
    end
    check("single_buttons", buttons, 4'b1010);
    check("single_valids", valid_cycles.size() - b_vc, 1);
    if (valid_cycles.size() > b_vc && latch_starts.size() > b_ls)
      check("single_latency", valid_cycles[b_vc] - latch_starts[b_ls], 19);

    // Periodic polling
    pad_word = 4'b0110;
    snap();
    auto_en = 1'b1;
    cycles(550);
    auto_en = 1'b0;
    cycles(30);
    check("auto_latches", latch_starts.size() - b_ls, 5);
    check("auto_valids", valid_cycles.size() - b_vc, 5);
    for (int i = 1; i < 5; i++) begin
      if (latch_starts.size() > b_ls + i)
        check($sformatf("auto_spacing%0d", i), latch_starts[b_ls+i] - latch_starts[b_ls+i-1], 100);
    end
    check("auto_buttons", buttons, 4'b0110);

    // Several requests during one poll collapse into a single follow-on poll
    pad_word = 4'b0001;
    snap();
    pulse_req();
    cycles(2);
    pulse_req();
    cycles(3);
    pulse_req();
    cycles(5);
    pulse_req();
    cycles(60);
    check("coal_latches", latch_starts.size() - b_ls, 2);
    check("coal_valids", valid_cycles.size() - b_vc, 2);
    if (latch_starts.size() > b_ls + 1)
      check("coal_gap", latch_starts[b_ls+1] - latch_starts[b_ls], 20);
    check("coal_buttons", buttons, 4'b0001);

    // Asynchronous reset during the second LOW phase
    pad_word = 4'b1111;
    pulse_req();
    cycles(10);
    check("mid_sclk_low", snes_clk, 0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_latch", snes_latch, 0);
    check("mid_rst_sclk", snes_clk, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_buttons", buttons, 0);
    check("mid_rst_valid", buttons_valid, 0);
    cycles(2);
    reset_n = 1'b1;
    snap();
    cycles(30);
    check("post_rst_latches", latch_starts.size() - b_ls, 0);
    check("post_rst_valids", valid_cycles.size() - b_vc, 0);
    check("post_rst_buttons", buttons, 0);
    check("post_rst_busy", busy, 0);

`ifdef SNES_CHANGE_EN
    pad_word = 4'b0011;
    snap();
    pulse_req();
    cycles(25);
    check("chg_first", changed_cnt - b_ch, 1);
    pulse_req();
    cycles(25);
    check("chg_same", changed_cnt - b_ch, 1);
    pad_word = 4'b0111;
    pulse_req();
    cycles(25);
    check("chg_third", changed_cnt - b_ch, 2);
    check("chg_buttons", buttons, 4'b0111);
`else
    check("chg_disabled", changed_cnt, 0);
`endif
    check("chg_orphan", changed_orphan, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
